// File: rtl/dpram_stream_reader_pkg.sv
// Shared definitions for the dual-port RAM stream reader.
//   - rd_state_e : reader FSM state encoding
//   - FifoDepth  : skid buffer depth (absorbs the one-cycle RAM read latency)
//   - bit_fit()  : number of bits needed to hold the value n
package dpram_stream_reader_pkg;

  localparam int unsigned FifoDepth = 2;
  localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);
  localparam int unsigned FifoPtrW  = $clog2(FifoDepth);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StFin   = 2'd3
  } rd_state_e;

  // Width that can represent the value n itself (so a count of DEPTH fits).
  function automatic int unsigned bit_fit(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) <= 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/dpram_rd_skid.sv
// dpram_rd_skid: 2-entry synchronous FIFO of {last, data} used as the skid
// buffer between the RAM read port and the output stream.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_clr              synchronous flush (drops all entries)
//   i_push, i_push_*   write one entry
//   i_pop              remove the head entry (caller guarantees non-empty)
//   o_count            number of stored entries
//   o_head_last/data   head entry
module dpram_rd_skid
  import dpram_stream_reader_pkg::*;
#(
  parameter int unsigned DBW = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_push,
  input  logic                i_push_last,
  input  logic [DBW-1:0]      i_push_data,
  input  logic                i_pop,
  output logic [FifoCntW-1:0] o_count,
  output logic                o_head_last,
  output logic [DBW-1:0]      o_head_data
);

  logic [DBW-1:0]      r_data [FifoDepth];
  logic                r_last [FifoDepth];
  logic [FifoPtrW-1:0] r_wr_ptr;
  logic [FifoPtrW-1:0] r_rd_ptr;
  logic [FifoCntW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_last[r_wr_ptr] <= i_push_last;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + FifoCntW'(i_push) - FifoCntW'(i_pop);
    end
  end

  assign o_count     = r_count;
  assign o_head_last = r_last[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

endmodule

// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader: read-side streaming engine for one port of the
// dual-port RAM. On iSTART it reads iLEN words from iBASE (wrapping modulo
// DEPTH) and presents them on a valid/ready stream with oST_LAST on the
// final beat. A 2-entry skid buffer absorbs the one-cycle RAM read latency.
// Ports:
//   iCLK, iRST            clock, synchronous active-high reset
//   iSTART, iBASE, iLEN   transfer command (ignored while oBUSY)
//   oBUSY, oDONE          status; oDONE is a one-cycle completion pulse
//   oRAM_ADDR/WR/WDATA    RAM port (write side tied off)
//   iRAM_RDATA            RAM read data, one cycle after the address
//   oST_VALID/DATA/LAST   output stream, iST_READY accepts
// Build option: DPRAM_RD_ABORT_EN adds iABORT, which ends a running
// transfer early, discarding undelivered data.
module dpram_stream_reader
  import dpram_stream_reader_pkg::*;
#(
  parameter int unsigned DBW   = 32,
  parameter int unsigned DEPTH = 1023,
  parameter int unsigned ABW   = bit_fit(DEPTH)
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic           iSTART,
  input  logic [ABW-1:0] iBASE,
  input  logic [ABW-1:0] iLEN,
`ifdef DPRAM_RD_ABORT_EN
  input  logic           iABORT,
`endif
  output logic           oBUSY,
  output logic           oDONE,
  output logic [ABW-1:0] oRAM_ADDR,
  output logic           oRAM_WR,
  output logic [DBW-1:0] oRAM_WDATA,
  input  logic [DBW-1:0] iRAM_RDATA,
  output logic           oST_VALID,
  output logic [DBW-1:0] oST_DATA,
  output logic           oST_LAST,
  input  logic           iST_READY
);

  localparam logic [ABW-1:0] LastAddr = ABW'(DEPTH - 1);
  localparam logic [ABW-1:0] MaxLen   = ABW'(DEPTH);

  rd_state_e      r_state;
  logic [ABW-1:0] r_addr;
  logic [ABW-1:0] r_remain;
  logic           r_inflight;
  logic           r_inflight_last;
  logic           r_busy;
  logic           r_done;

  logic [FifoCntW-1:0] w_count;
  logic                w_head_last;
  logic [DBW-1:0]      w_head_data;
  logic                w_valid;
  logic                w_pop;
  logic [FifoCntW:0]   w_occ;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_push;
  logic                w_abort;
  logic [ABW-1:0]      w_len_c;
  logic [ABW-1:0]      w_base_c;

`ifdef DPRAM_RD_ABORT_EN
  assign w_abort = iABORT & r_busy;
`else
  assign w_abort = 1'b0;
`endif

  assign w_len_c  = (iLEN > MaxLen) ? MaxLen : iLEN;
  assign w_base_c = (iBASE >= MaxLen) ? '0 : iBASE;

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & iST_READY;

  // Occupancy the FIFO will have once the in-flight word lands and this
  // cycle's pop completes; a new read is only issued if it will fit.
  assign w_occ = {1'b0, w_count} + (FifoCntW + 1)'(r_inflight) - (FifoCntW + 1)'(w_pop);

  assign w_issue      = (r_state == StRun) && (r_remain != '0) &&
                        (w_occ < (FifoCntW + 1)'(FifoDepth)) && !w_abort;
  assign w_last_issue = w_issue && (r_remain == ABW'(1));
  assign w_push       = r_inflight & ~w_abort;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state         <= StIdle;
      r_addr          <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      if (w_issue) begin
        r_addr   <= (r_addr == LastAddr) ? '0 : r_addr + 1'b1;
        r_remain <= r_remain - 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (iSTART) begin
            if (w_len_c != '0) begin
              r_state  <= StRun;
              r_addr   <= w_base_c;
              r_remain <= w_len_c;
              r_busy   <= 1'b1;
            end else begin
              r_state <= StFin;
              r_done  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_abort) begin
            r_state <= StFin;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_last_issue) begin
            r_state <= StFlush;
          end
        end
        StFlush: begin
          if (w_abort || (w_pop && w_head_last)) begin
            r_state <= StFin;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        StFin: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  dpram_rd_skid #(
    .DBW (DBW)
  ) u_skid (
    .i_clk       (iCLK),
    .i_rst       (iRST),
    .i_clr       (w_abort),
    .i_push      (w_push),
    .i_push_last (r_inflight_last),
    .i_push_data (iRAM_RDATA),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_last (w_head_last),
    .o_head_data (w_head_data)
  );

  assign oBUSY      = r_busy;
  assign oDONE      = r_done;
  assign oRAM_ADDR  = r_addr;
  assign oRAM_WR    = 1'b0;
  assign oRAM_WDATA = '0;
  assign oST_VALID  = w_valid;
  assign oST_DATA   = w_head_data;
  assign oST_LAST   = w_valid & w_head_last;

endmodule

// File: doc/dpram_stream_reader.md
# dpram_stream_reader

Read-side streaming engine for one port of the team's parameterized dual-port RAM. On a start command it walks a contiguous, wrapping address range, absorbs the RAM's one-cycle registered read latency with a 2-entry skid buffer, and presents the words on a valid/ready stream. It is paired with a producer that writes the other RAM port, for example a frame or packet buffer drained toward a bus or a display.

## Interface
- DBW, 32, data width; must equal the RAM's DBW
- DEPTH, 1023, RAM word count; ABW = bit_fit(DEPTH), using the shared bit_fit.vh function
- iCLK  in  1  single clock for all logic
- iRST  in  1  reset; synchronous, active-high
- iSTART  in  1  one-cycle command strobe; ignored while oBUSY=1
- iBASE  in  ABW  first word address, captured with iSTART
- iLEN  in  ABW  word count, captured with iSTART
- oBUSY  out  1  transfer in progress
- oDONE  out  1  one-cycle completion pulse
- oRAM_ADDR  out  ABW  RAM port address
- oRAM_WR  out  1  constant 0
- oRAM_WDATA  out  DBW  constant 0
- iRAM_RDATA  in  DBW  RAM read data, registered one cycle after the address
- oST_VALID  out  1  stream beat valid
- oST_DATA  out  DBW  stream beat data
- oST_LAST  out  1  marks the final beat of a transfer
- iST_READY  in  1  downstream accept

## Operation
- FSM states: IDLE, RUN, FLUSH, FIN.
  - IDLE -> RUN on iSTART when iLEN != 0.
  - IDLE -> FIN on iSTART when iLEN = 0. No RAM reads and no beats occur.
  - RUN -> FLUSH when the last read has been issued.
  - FLUSH -> FIN when the last beat handshakes (oST_VALID & iST_READY & oST_LAST).
  - FIN -> IDLE unconditionally.
- Capture rules:
  - iLEN > DEPTH is clamped to DEPTH.
  - iBASE >= DEPTH is replaced by 0.
- Addressing:
  - Read address starts at the captured base and increments by 1 per issued read.
  - Wrap rule: DEPTH-1 is followed by 0. Wrapping is modulo DEPTH, not 2^ABW.
- Issue rule (RUN only): a read issues when reads remain and (fifo_count + inflight − pop) < 2, where pop = oST_VALID & iST_READY. At most one read is in flight.
- Data path:
  - Read data is written into the 2-entry FIFO in the cycle after the read issues.
  - The head of the FIFO drives oST_DATA.
  - oST_LAST is stored per entry and is set on the entry for the final address.
- Stream rule: while oST_VALID=1 and iST_READY=0, oST_DATA and oST_LAST are held stable. No beat is lost or duplicated.
- Status outputs:
  - oBUSY=1 in RUN and FLUSH.
  - oDONE=1 only in FIN.
- Reset: iRST clears all state regardless of the current state (mid-transfer included). The FIFO is emptied, the state returns to IDLE, and in-flight data is discarded.
- Reset values: oBUSY=0, oDONE=0, oST_VALID=0, oST_LAST=0, oST_DATA=0, oRAM_ADDR=0.

## Timing
- Edge E0 samples iSTART.
- oRAM_ADDR=base in the cycle after E0.
- First oST_VALID=1 after E2. Start-to-first-beat latency is therefore 2 cycles.
- With iST_READY held at 1, throughput is 1 beat per cycle with no bubbles.
- oDONE rises on the edge after the last handshake. oBUSY falls on that same edge.
- iSTART is accepted again in FIN-exit IDLE, so back-to-back transfers have a 2-cycle gap from the last beat.
- The combinational path iST_READY -> issue -> oRAM_ADDR is permitted.

## Configuration
- DPRAM_RD_ABORT_EN
- Defined:
  - Adds input iABORT (1 bit).
  - iABORT=1 in RUN or FLUSH stops further reads, drops the in-flight read, empties the FIFO, and goes to FIN.
  - oDONE pulses. Any oST_LAST beat not yet delivered is never emitted.
- Undefined: no iABORT port; a transfer always runs to completion.

## Structure
- Shared header (alongside bit_fit.vh): FSM state encodings and the FIFO depth constant (2).
- One sub-module, dpram_rd_skid: a 2-entry synchronous FIFO of {last, data} with push/pop/count. It uses the same clock and reset.

## Test plan
- DEPTH=16, RAM preloaded with word[i]=i. iBASE=3, iLEN=5, iST_READY=1 -> beats 3,4,5,6,7; oST_LAST on 7; first beat 2 cycles after start; oDONE one cycle after the last beat.
- iBASE=14, iLEN=4 -> beats 14,15,0,1 (wrap modulo DEPTH); oRAM_ADDR never equals 16.
- Random iST_READY (50%), iLEN=16 -> all 16 words in order; data and last held stable while stalled; no gaps with iST_READY=1.
- iLEN=0 -> no RAM address change and no oST_VALID; oDONE pulses 1 cycle after start. Also: iSTART while busy is ignored.
- iRST asserted mid-transfer after 3 beats -> next cycle oBUSY=0, oST_VALID=0, oDONE=0. A new start then reads correctly from its own base.
- With DPRAM_RD_ABORT_EN, iABORT after 2 of 8 beats -> no further beats, oDONE pulses, the next transfer is clean.
